uart_word_packer: RTL and testbench
===================================

# uart_word_packer

Receive-side word assembler for the UART link between MIRCore and its peer UART module. It sits between a `UARTModule` byte output (`wb_flag`/`wb_data`) and the core's 32-bit input path, packing four received bytes into one 32-bit word. It is the reader for the core's 32-bit `write_value` sent out through the transmitting UART. It holds each word until the core acknowledges it, and flags overruns and stalled partial words.

## Interface
- `LITTLE_ENDIAN`, 1, 1: first received byte lands in `word_data[7:0]`; 0: first byte lands in `word_data[31:24]`
- `TIMEOUT_CYCLES`, 434000, idle cycles allowed between bytes of one word before the partial word is discarded (must be ≥ 2)
- `TO_W`, 20, width of timeout counter; must hold `TIMEOUT_CYCLES-1`
- `clock` in 1: core clock, single clock domain, rising edge
- `reset` in 1: synchronous, active-low
- `wb_flag` in 1: byte-available level from the UART module; a new byte is signalled by its rising edge
- `wb_data` in 8: received byte, stable while `wb_flag` is high
- `word_ack` in 1: core consumes `word_data` this cycle; ignored when `word_valid`=0
- `clear_err` in 1: clears sticky `overrun` and `timeout_err`
- `word_data` out 32: assembled word; holds last value when not valid
- `word_valid` out 1: a complete word is waiting
- `byte_count` out 3: bytes collected toward the current word (0–4)
- `overrun` out 1: sticky, a byte was dropped
- `timeout_err` out 1: sticky, a partial word was discarded

## Operation
- Edge detect: register `wb_prev` holds `wb_flag` from the previous cycle. A byte is captured when `wb_flag`=1 and `wb_prev`=0 (`cap`). A held-high `wb_flag` yields exactly one byte.
- States:
  - IDLE: `byte_count`=0.
  - COLLECT: `byte_count` is 1–3.
  - FULL: `word_valid`=1, `byte_count`=4.
- Transitions:
  - IDLE: on `cap`, write the byte to lane 0 and go to COLLECT.
  - COLLECT: on `cap`, write the byte to lane `byte_count` and increment. When the 4th byte is captured, go to FULL.
  - FULL: on `word_ack`, go to IDLE.
- Lane mapping: lane k occupies bits `[8k+7:8k]` when `LITTLE_ENDIAN`=1, and bits `[31-8k:24-8k]` otherwise.
- FULL with `cap` and no `word_ack`: the byte is dropped, `overrun` is set, and the state is unchanged.
- FULL with `cap` and `word_ack` in the same cycle: the word is released and the byte becomes lane 0 of the next word. Next state is COLLECT with `byte_count`=1. `word_data` keeps the old word in its other lanes.
- `clear_err` and a new error event in the same cycle: the flag ends up set (set wins).
- Reset values: `word_data`=0, `word_valid`=0, `byte_count`=0, `overrun`=0, `timeout_err`=0, `wb_prev`=0, state IDLE.
- Reset mid-word discards the partial word and raises no error flag.

## Timing
- Capture latency: one clock from the cycle in which the edge is seen to the registered update. `byte_count` increments in the next cycle.
- `word_valid` rises in the cycle after the 4th `cap`. The earliest `word_ack` is accepted in that same cycle, and `word_valid` falls the cycle after.
- Back-to-back bytes need `wb_flag` low for at least one clock between bytes.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `UART_PACKER_TIMEOUT_EN` defined:
  - In COLLECT, a counter clears on each `cap` and increments otherwise.
  - When it reaches `TIMEOUT_CYCLES-1` with no `cap`, state goes to IDLE, `byte_count`=0, and `timeout_err` is set.
  - A `cap` in the expiry cycle wins: no timeout occurs.
- `UART_PACKER_TIMEOUT_EN` undefined:
  - There is no counter, and partial words are held indefinitely.
  - `timeout_err` is tied to 0.

## Structure
- Shared package `uart_pkg`:
  - state enum `{PK_IDLE, PK_COLLECT, PK_FULL}`
  - `UART_BYTES_PER_WORD`=4
  - `UART_BYTE_W`=8
- One sub-module, `uart_edge_detect`: a registered rising-edge detector producing `cap` from `wb_flag`, reset to 0. It is reused by later UART blocks.
- The lane-index to bit-slice mapping is a function in `uart_pkg`.

## Test plan
- LE: bytes 0x11, 0x22, 0x33, 0x44, each a 1-cycle `wb_flag` pulse 3 cycles apart -> `word_data`=0x44332211 and `word_valid`=1 one cycle after the 4th pulse; `byte_count` steps 1→4.
- BE: same bytes with `LITTLE_ENDIAN`=0 -> `word_data`=0x11223344; a `wb_flag` held high for 10 cycles counts as one byte only.
- FULL, then 5th byte 0x55 with no ack -> `overrun`=1 and `word_data` unchanged. `clear_err` -> `overrun`=0.
- FULL, with 0x55 `cap` and `word_ack` in the same cycle -> `word_valid`=0, `byte_count`=1, `word_data[7:0]`=0x55 (LE), `overrun`=0.
- With `UART_PACKER_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16: send two bytes, then idle for 16 cycles -> `timeout_err`=1 and `byte_count`=0. Next, four bytes -> a clean word.
- `reset`=0 for one cycle after 3 bytes -> all outputs 0. The next four bytes form a word, and no error flags are set.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared types, sizes and byte-lane mapping for the UART word path
package uart_pkg;
  typedef enum logic [1:0] {PK_IDLE, PK_COLLECT, PK_FULL} pk_state_t;
  localparam int UART_BYTES_PER_WORD = 4;
  localparam int UART_BYTE_W = 8;
  function automatic logic [4:0] lane_lsb(input logic [1:0] lane, input logic little_endian);
    return little_endian ? {lane, 3'b000} : 5'(5'd24 - {lane, 3'b000});
  endfunction
endpackage

// File: rtl/uart_edge_detect.sv
// uart_edge_detect: registered-history rising-edge detector, history reset to 0 by active-low reset
module uart_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic sig,
  output logic rise
);
  logic prev;
  always_ff @(posedge clock) begin
    if (!reset) prev <= 1'b0;
    else prev <= sig;
  end
  assign rise = sig & ~prev;
endmodule

// File: rtl/uart_word_packer.sv
// uart_word_packer: packs four UART bytes into a 32-bit word; define UART_PACKER_TIMEOUT_EN to discard stalled partial words
module uart_word_packer
  import uart_pkg::*;
#(
  parameter bit LITTLE_ENDIAN = 1'b1,
  parameter int TIMEOUT_CYCLES = 434000,
  parameter int TO_W = 20
) (
  input  logic clock,
  input  logic reset,
  input  logic wb_flag,
  input  logic [UART_BYTE_W-1:0] wb_data,
  input  logic word_ack,
  input  logic clear_err,
  output logic [UART_BYTES_PER_WORD*UART_BYTE_W-1:0] word_data,
  output logic word_valid,
  output logic [2:0] byte_count,
  output logic overrun,
  output logic timeout_err
);
  pk_state_t state, state_n;
  logic cap, wr, ovr_set, expire;
  logic [2:0] cnt_n;
  logic [1:0] lane;
  uart_edge_detect u_edge (.clock(clock), .reset(reset), .sig(wb_flag), .rise(cap));
`ifdef UART_PACKER_TIMEOUT_EN
  logic [TO_W-1:0] tmr;
  assign expire = state == PK_COLLECT && !cap && tmr == TO_W'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clock) begin
    if (!reset) begin
      tmr <= '0;
      timeout_err <= 1'b0;
    end else begin
      tmr <= (state == PK_COLLECT && !cap && !expire) ? tmr + 1'b1 : '0;
      timeout_err <= expire ? 1'b1 : clear_err ? 1'b0 : timeout_err;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{TO_W'(TIMEOUT_CYCLES - 1)};
  assign expire = 1'b0;
  assign timeout_err = 1'b0;
`endif
  always_comb begin
    state_n = state;
    cnt_n = byte_count;
    lane = 2'd0;
    wr = 1'b0;
    ovr_set = 1'b0;
    case (state)
      PK_IDLE: begin
        wr = cap;
        cnt_n = cap ? 3'd1 : 3'd0;
        state_n = cap ? PK_COLLECT : PK_IDLE;
      end
      PK_COLLECT: begin
        lane = byte_count[1:0];
        wr = cap;
        cnt_n = cap ? byte_count + 3'd1 : expire ? 3'd0 : byte_count;
        state_n = cap ? (byte_count == 3'd3 ? PK_FULL : PK_COLLECT) : expire ? PK_IDLE : PK_COLLECT;
      end
      PK_FULL: begin
        wr = word_ack & cap;
        ovr_set = ~word_ack & cap;
        cnt_n = word_ack ? {2'b00, cap} : 3'd4;
        state_n = word_ack ? (cap ? PK_COLLECT : PK_IDLE) : PK_FULL;
      end
      default: state_n = PK_IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= PK_IDLE;
      byte_count <= 3'd0;
      word_data <= '0;
      overrun <= 1'b0;
    end else begin
      state <= state_n;
      byte_count <= cnt_n;
      if (wr) word_data[lane_lsb(lane, LITTLE_ENDIAN) +: UART_BYTE_W] <= wb_data;
      overrun <= ovr_set ? 1'b1 : clear_err ? 1'b0 : overrun;
    end
  end
  assign word_valid = state == PK_FULL;
endmodule

// File: tb/tb_uart_word_packer.sv
// tb_uart_word_packer: directed checks of little- and big-endian packers driven in parallel
module tb_uart_word_packer;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic wb_flag = 1'b0;
  logic [7:0] wb_data = 8'h00;
  logic word_ack = 1'b0;
  logic clear_err = 1'b0;
  logic [31:0] le_word, be_word;
  logic le_valid, be_valid, le_ovr, be_ovr, le_to, be_to;
  logic [2:0] le_count, be_count;
  logic [5:0] le_st, be_st;
  int checks = 0;
  int fails = 0;
  always #5 clock = ~clock;
  assign le_st = {le_valid, le_count, le_ovr, le_to};
  assign be_st = {be_valid, be_count, be_ovr, be_to};
  uart_word_packer #(.LITTLE_ENDIAN(1'b1), .TIMEOUT_CYCLES(16), .TO_W(5)) dut_le (
    .clock(clock), .reset(reset), .wb_flag(wb_flag), .wb_data(wb_data), .word_ack(word_ack),
    .clear_err(clear_err), .word_data(le_word), .word_valid(le_valid), .byte_count(le_count),
    .overrun(le_ovr), .timeout_err(le_to));
  uart_word_packer #(.LITTLE_ENDIAN(1'b0), .TIMEOUT_CYCLES(16), .TO_W(5)) dut_be (
    .clock(clock), .reset(reset), .wb_flag(wb_flag), .wb_data(wb_data), .word_ack(word_ack),
    .clear_err(clear_err), .word_data(be_word), .word_valid(be_valid), .byte_count(be_count),
    .overrun(be_ovr), .timeout_err(be_to));
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic send_byte(input logic [7:0] b);
    wb_data = b;
    wb_flag = 1'b1;
    tick();
    wb_flag = 1'b0;
    tick();
    tick();
  endtask
  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    checks++; if (le_word !== 32'h0) begin fails++; $display("FAIL reset_le_word got %h want 00000000", le_word); end
    checks++; if (be_word !== 32'h0) begin fails++; $display("FAIL reset_be_word got %h want 00000000", be_word); end
    checks++; if (le_st !== 6'b0) begin fails++; $display("FAIL reset_le_status got %b want 000000", le_st); end
    checks++; if (be_st !== 6'b0) begin fails++; $display("FAIL reset_be_status got %b want 000000", be_st); end
    reset = 1'b1;
    tick();
  endtask
  task automatic test_word();
    send_byte(8'h11);
    checks++; if (le_count !== 3'd1) begin fails++; $display("FAIL word_count1 got %0d want 1", le_count); end
    send_byte(8'h22);
    checks++; if (le_count !== 3'd2) begin fails++; $display("FAIL word_count2 got %0d want 2", le_count); end
    send_byte(8'h33);
    checks++; if (le_st !== 6'b0_011_0_0) begin fails++; $display("FAIL word_status3 got %b want 001100", le_st); end
    wb_data = 8'h44;
    wb_flag = 1'b1;
    tick();
    wb_flag = 1'b0;
    checks++; if (le_st !== 6'b1_100_0_0) begin fails++; $display("FAIL word_status4 got %b want 110000", le_st); end
    checks++; if (le_word !== 32'h44332211) begin fails++; $display("FAIL word_le got %h want 44332211", le_word); end
    checks++; if (be_word !== 32'h11223344) begin fails++; $display("FAIL word_be got %h want 11223344", be_word); end
    word_ack = 1'b1;
    tick();
    word_ack = 1'b0;
    checks++; if (le_st !== 6'b0) begin fails++; $display("FAIL word_ack_status got %b want 000000", le_st); end
    checks++; if (le_word !== 32'h44332211) begin fails++; $display("FAIL word_hold got %h want 44332211", le_word); end
    tick();
  endtask
  task automatic test_hold_high();
    wb_data = 8'hA5;
    wb_flag = 1'b1;
    repeat (10) tick();
    wb_flag = 1'b0;
    tick();
    checks++; if (le_count !== 3'd1) begin fails++; $display("FAIL hold_le_count got %0d want 1", le_count); end
    checks++; if (be_count !== 3'd1) begin fails++; $display("FAIL hold_be_count got %0d want 1", be_count); end
    send_byte(8'hB6);
    send_byte(8'hC7);
    send_byte(8'hD8);
    checks++; if (le_word !== 32'hD8C7B6A5) begin fails++; $display("FAIL hold_le_word got %h want d8c7b6a5", le_word); end
    checks++; if (be_word !== 32'hA5B6C7D8) begin fails++; $display("FAIL hold_be_word got %h want a5b6c7d8", be_word); end
  endtask
  task automatic test_overrun();
    send_byte(8'h55);
    checks++; if (le_st !== 6'b1_100_1_0) begin fails++; $display("FAIL ovr_status got %b want 110010", le_st); end
    checks++; if (le_word !== 32'hD8C7B6A5) begin fails++; $display("FAIL ovr_word got %h want d8c7b6a5", le_word); end
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    checks++; if (le_ovr !== 1'b0) begin fails++; $display("FAIL ovr_clear got %b want 0", le_ovr); end
    wb_data = 8'h5A;
    wb_flag = 1'b1;
    clear_err = 1'b1;
    tick();
    wb_flag = 1'b0;
    clear_err = 1'b0;
    checks++; if (be_ovr !== 1'b1) begin fails++; $display("FAIL ovr_set_wins got %b want 1", be_ovr); end
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    tick();
  endtask
  task automatic test_ack_cap();
    wb_data = 8'h55;
    wb_flag = 1'b1;
    word_ack = 1'b1;
    tick();
    wb_flag = 1'b0;
    word_ack = 1'b0;
    checks++; if (le_st !== 6'b0_001_0_0) begin fails++; $display("FAIL ackcap_status got %b want 000100", le_st); end
    checks++; if (le_word !== 32'hD8C7B655) begin fails++; $display("FAIL ackcap_le_word got %h want d8c7b655", le_word); end
    checks++; if (be_word !== 32'h55B6C7D8) begin fails++; $display("FAIL ackcap_be_word got %h want 55b6c7d8", be_word); end
    tick();
    send_byte(8'h66);
    send_byte(8'h77);
    send_byte(8'h88);
    checks++; if (le_word !== 32'h88776655) begin fails++; $display("FAIL ackcap_next got %h want 88776655", le_word); end
    word_ack = 1'b1;
    tick();
    word_ack = 1'b0;
    tick();
  endtask
  task automatic test_timeout();
    send_byte(8'h01);
    send_byte(8'h02);
    repeat (10) tick();
    checks++; if (le_st !== 6'b0_010_0_0) begin fails++; $display("FAIL to_early got %b want 001000", le_st); end
    repeat (10) tick();
`ifdef UART_PACKER_TIMEOUT_EN
    checks++; if (le_st !== 6'b0_000_0_1) begin fails++; $display("FAIL to_expired got %b want 000001", le_st); end
    send_byte(8'h10);
    send_byte(8'h20);
    send_byte(8'h30);
    send_byte(8'h40);
    checks++; if (le_word !== 32'h40302010) begin fails++; $display("FAIL to_next_word got %h want 40302010", le_word); end
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    checks++; if (le_st !== 6'b1_100_0_0) begin fails++; $display("FAIL to_cleared got %b want 110000", le_st); end
`else
    checks++; if (le_st !== 6'b0_010_0_0) begin fails++; $display("FAIL to_held got %b want 001000", le_st); end
    send_byte(8'h03);
    send_byte(8'h04);
    checks++; if (le_word !== 32'h04030201) begin fails++; $display("FAIL to_resume got %h want 04030201", le_word); end
    checks++; if (le_st !== 6'b1_100_0_0) begin fails++; $display("FAIL to_resume_status got %b want 110000", le_st); end
`endif
    word_ack = 1'b1;
    tick();
    word_ack = 1'b0;
    tick();
  endtask
  task automatic test_reset_mid();
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checks++; if (le_word !== 32'h0) begin fails++; $display("FAIL mid_word got %h want 00000000", le_word); end
    checks++; if (le_st !== 6'b0) begin fails++; $display("FAIL mid_status got %b want 000000", le_st); end
    tick();
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    checks++; if (le_word !== 32'h04030201) begin fails++; $display("FAIL mid_le_word got %h want 04030201", le_word); end
    checks++; if (be_word !== 32'h01020304) begin fails++; $display("FAIL mid_be_word got %h want 01020304", be_word); end
    checks++; if (be_st !== 6'b1_100_0_0) begin fails++; $display("FAIL mid_status_after got %b want 110000", be_st); end
  endtask
  initial begin
    test_reset();
    test_word();
    test_hold_high();
    test_overrun();
    test_ack_cap();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
